// File: rtl/multi_bit_fast2slow.sv
// Fast-to-slow multi-bit transfer using a toggle req/ack handshake.
// The slow domain is the same clock qualified by clkb_en; only req and ack cross.
module multi_bit_fast2slow #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clka,
  input  logic                  rst,
  input  logic                  clkb_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  valid_in,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid_out
);

  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  req_q, req_d;
  logic                  s1_q, s1_d;
  logic                  s2_q, s2_d;
  logic                  s3_q, s3_d;
  logic                  a1_q, a1_d;
  logic                  a2_q, a2_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_out_q, valid_out_d;
  logic                  accept;

  // busy spans from the req toggle until the ack edge has been synchronised back.
  assign busy      = req_q ^ a2_q;
  assign accept    = valid_in && !busy;
  assign dout      = dout_q;
  assign valid_out = valid_out_q;

  always_comb begin
    hold_d      = hold_q;
    req_d       = req_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    dout_d      = dout_q;
    valid_out_d = valid_out_q;
    a1_d        = s3_q;
    a2_d        = a1_q;

    if (accept) begin
      hold_d = din;
      req_d  = ~req_q;
    end

    // hold_q is stable while busy, so it is safe to sample on the detected req edge.
    if (clkb_en) begin
      s1_d = req_q;
      s2_d = s1_q;
      s3_d = s2_q;
      if (s2_q != s3_q) begin
        dout_d      = hold_q;
        valid_out_d = 1'b1;
      end else begin
        valid_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!rst) begin
      hold_q      <= '0;
      req_q       <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      a1_q        <= 1'b0;
      a2_q        <= 1'b0;
      dout_q      <= '0;
      valid_out_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      req_q       <= req_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      dout_q      <= dout_d;
      valid_out_q <= valid_out_d;
    end
  end

endmodule

// File: tb/tb_multi_bit_fast2slow.sv
// Directed bench for multi_bit_fast2slow: reset, slow-tick delivery, drop-while-busy,
// abort on reset and back-to-back traffic with the slow tick tied high.
module tb_multi_bit_fast2slow;

  logic       clka = 1'b0;
  logic       rst = 1'b0;
  logic       clkb_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       valid_in = 1'b0;
  logic       busy;
  logic [7:0] dout;
  logic       valid_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   phase = 0;
  logic tied = 1'b0;
  logic last_en = 1'b0;

  multi_bit_fast2slow #(.DATA_WIDTH(8)) dut (
    .clka      (clka),
    .rst       (rst),
    .clkb_en   (clkb_en),
    .din       (din),
    .valid_in  (valid_in),
    .busy      (busy),
    .dout      (dout),
    .valid_out (valid_out)
  );

  initial forever #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clka cycle; clkb_en is high every third edge unless tied.
  task automatic step();
    clkb_en = tied ? 1'b1 : (phase == 0);
    last_en = clkb_en;
    phase   = (phase == 2) ? 0 : phase + 1;
    @(posedge clka);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One full transfer with latency, pulse width and busy release checked.
  task automatic xfer(input logic [7:0] d, input int period);
    int ticks = 0;
    int early = 0;
    int hi = 0;
    din = d;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    $display("xfer din=%0h accepted", d);
    chk("busy_rise", busy, 1);
    for (int k = 0; k < 40 && ticks < 3; k++) begin
      step();
      if (last_en) ticks++;
      if (ticks < 3 && valid_out) early++;
    end
    chk("ticks_to_delivery", ticks, 3);
    chk("valid_out_early", early, 0);
    chk("valid_out_rise", valid_out, 1);
    chk("dout_delivered", dout, d);
    hi = 1;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 1) chk("busy_still_high", busy, 1);
      if (j == 2) chk("busy_fall", busy, 0);
      if (valid_out) hi++;
    end
    chk("valid_out_width", hi, period);
    chk("dout_hold", dout, d);
    $display("xfer dout=%0h width=%0d", dout, hi);
  endtask

  initial begin
    int deliv;
    int badv;
    logic [7:0] got[$];
    logic [7:0] exp_words[4];

    // 1: reset held with valid_in active
    rst = 1'b0;
    din = 8'hAA;
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_dout", dout, 0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_busy", busy, 0);
    end
    valid_in = 1'b0;
    rst = 1'b1;
    deliv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_out) deliv++;
    end
    chk("post_rst_no_pulse", deliv, 0);
    $display("reset phase done");

    // 2, 3: slow tick every third cycle
    xfer(8'h01, 3);
    idle(9);
    xfer(8'h02, 3);
    idle(9);
    xfer(8'h03, 3);
    idle(10);
    chk("dout_keeps_3", dout, 8'h03);

    // 4: second request while busy is dropped
    din = 8'h05;
    valid_in = 1'b1;
    step();
    din = 8'h09;
    step();
    chk("busy_during_drop", busy, 1);
    valid_in = 1'b0;
    deliv = 0;
    badv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_out) begin
        deliv++;
        if (dout !== 8'h05) badv++;
      end
    end
    chk("drop_pulse_cycles", deliv, 3);
    chk("drop_wrong_data", badv, 0);
    chk("drop_dout", dout, 8'h05);
    chk("drop_busy_idle", busy, 0);
    $display("drop test dout=%0h", dout);

    // 5: abort by reset mid-flight
    din = 8'h66;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("abort_busy_before", busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("abort_busy_after", busy, 0);
    chk("abort_dout_cleared", dout, 0);
    deliv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_out) deliv++;
    end
    chk("abort_no_pulse", deliv, 0);
    xfer(8'h07, 3);

    // 6: tick tied high, valid_in held with incrementing data
    tied = 1'b1;
    idle(3);
    exp_words[0] = 8'h10;
    exp_words[1] = 8'h16;
    exp_words[2] = 8'h1C;
    exp_words[3] = 8'h22;
    valid_in = 1'b1;
    for (int i = 0; i < 24; i++) begin
      din = 8'h10 + 8'(i);
      step();
      if (valid_out) got.push_back(dout);
    end
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_out) got.push_back(dout);
    end
    chk("b2b_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk($sformatf("b2b_word%0d", i), got[i], exp_words[i]);
      $display("b2b delivery %0d dout=%0h", i, got[i]);
    end
    chk("b2b_busy_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
